muldiv_issue: RTL and testbench

MULDIV_ISSUE -- requirements
Module: muldiv_issue

---
 rtl/md_pkg.sv | 48 ++++
 rtl/md_pend_buf.sv | 59 +++++
 rtl/muldiv_issue.sv | 130 +++++++++++++
 tb/tb_muldiv_issue.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared muldiv definitions: decode command type, muldiv OP encodings and helpers.
package md_pkg;

    // Decode-stage muldiv command as delivered by the instruction decoder.
    typedef enum logic [2:0] {
        MD_NOP  = 3'd0,
        MD_MUL  = 3'd1,
        MD_MAD  = 3'd2,
        MD_MTLO = 3'd3,
        MD_MTHI = 3'd4,
        MD_DIV  = 3'd5,
        MD_MFLO = 3'd6,
        MD_MFHI = 3'd7
    } md_cmd_t;

    // OP field encodings understood by the muldiv unit.
    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_MAD  = 3'b001;
    localparam logic [2:0] OP_MTLO = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b011;

    // Translate a decode command into the muldiv OP field (non-write commands map to MUL).
    function automatic logic [2:0] md_cmd_to_op(input md_cmd_t cmd);
        logic [2:0] op;
        case (cmd)
            MD_MUL:  op = OP_MUL;
            MD_MAD:  op = OP_MAD;
            MD_MTLO: op = OP_MTLO;
            MD_MTHI: op = OP_MTHI;
            MD_DIV:  op = OP_DIV;
            default: op = OP_MUL;
        endcase
        return op;
    endfunction

    // Commands that change HI/LO and therefore need an issue slot.
    function automatic logic md_is_write(input md_cmd_t cmd);
        return (cmd == MD_MUL) || (cmd == MD_MAD) || (cmd == MD_MTLO) ||
               (cmd == MD_MTHI) || (cmd == MD_DIV);
    endfunction

    // Commands that only read HI/LO.
    function automatic logic md_is_read(input md_cmd_t cmd);
        return (cmd == MD_MFLO) || (cmd == MD_MFHI);
    endfunction

endpackage

// File: rtl/md_pend_buf.sv
// One-entry pending buffer for a muldiv write op that could not issue immediately.
module md_pend_buf
    import md_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         unload_i,
    input  md_cmd_t      cmd_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         full_o,
    output md_cmd_t      cmd_o,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]   state_q, state_d;
    md_cmd_t      cmd_q;
    logic [W-1:0] a_q, b_q;

    // A load always leaves the entry occupied, even when the old op drains in the same cycle.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = ST_FULL;
        end else if (unload_i) begin
            state_d = ST_EMPTY;
        end
    end

    // State and payload registers; reset drops whatever op was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cmd_q   <= MD_NOP;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load_i) begin
                cmd_q <= cmd_i;
                a_q   <= a_i;
                b_q   <= b_i;
            end
        end
    end

    assign full_o = (state_q == ST_FULL);
    assign cmd_o  = cmd_q;
    assign a_o    = a_q;
    assign b_o    = b_q;

endmodule

// File: rtl/muldiv_issue.sv
// Issue control between the decode stage and the multi-cycle muldiv unit.
module muldiv_issue
    import md_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid_i,
    input  logic [2:0]   id_cmd_i,
    input  logic [W-1:0] id_a_i,
    input  logic [W-1:0] id_b_i,
    input  logic         flush_i,
    input  logic         md_busy_i,
    output logic         md_en_o,
    output logic [2:0]   md_op_o,
    output logic [W-1:0] md_a_o,
    output logic [W-1:0] md_b_o,
    output logic         stall_o,
    output logic         rd_valid_o,
    output logic         rd_hi_o,
    output logic [15:0]  stall_cnt_o
);

    md_cmd_t      idCmd;
    logic         idLive, idWrite, idRead;
    logic         shadow_q, shadow_d;
    logic [15:0]  stallCnt_q, stallCnt_d;
    logic         unitFree;
    logic         bufFull, bufLoad, issueBuf, issueId;
    logic         stallNow, rdValidNow;
    md_cmd_t      bufCmd;
    logic [W-1:0] bufA, bufB;

    // A flushed or reset-time decode op is treated exactly like a bubble.
    assign idCmd    = md_cmd_t'(id_cmd_i);
    assign idLive   = id_valid_i && !flush_i && rst_n;
    assign idWrite  = idLive && md_is_write(idCmd);
    assign idRead   = idLive && md_is_read(idCmd);
    assign unitFree = !md_busy_i && !shadow_q;

    md_pend_buf #(.W(W)) u_pend_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (bufLoad),
        .unload_i (issueBuf),
        .cmd_i    (idCmd),
        .a_i      (id_a_i),
        .b_i      (id_b_i),
        .full_o   (bufFull),
        .cmd_o    (bufCmd),
        .a_o      (bufA),
        .b_o      (bufB)
    );

    // Issue arbitration: the older buffered op always wins the slot; reads wait for a drained, idle unit.
    always_comb begin
        issueBuf   = 1'b0;
        issueId    = 1'b0;
        bufLoad    = 1'b0;
        stallNow   = 1'b0;
        rdValidNow = 1'b0;
        if (bufFull) begin
            if (unitFree) begin
                issueBuf = 1'b1;
                bufLoad  = idWrite;
            end
            stallNow = idRead || (idWrite && !unitFree);
        end else begin
            if (idWrite) begin
                if (unitFree) begin
                    issueId = 1'b1;
                end else begin
                    bufLoad = 1'b1;
                end
            end
            if (idRead) begin
                if (unitFree) begin
                    rdValidNow = 1'b1;
                end else begin
                    stallNow = 1'b1;
                end
            end
        end
    end

    // Muldiv request mux; operands are forced to zero when nothing issues so they never carry X.
    always_comb begin
        md_op_o = '0;
        md_a_o  = '0;
        md_b_o  = '0;
        if (issueBuf) begin
            md_op_o = md_cmd_to_op(bufCmd);
            md_a_o  = bufA;
            md_b_o  = bufB;
        end else if (issueId) begin
            md_op_o = md_cmd_to_op(idCmd);
            md_a_o  = id_a_i;
            md_b_o  = id_b_i;
        end
    end

    assign md_en_o    = issueBuf || issueId;
    assign stall_o    = stallNow;
    assign rd_valid_o = rdValidNow;
    assign rd_hi_o    = rdValidNow && (idCmd == MD_MFHI);

    // Next-state for the post-issue shadow and the saturating stall counter.
    always_comb begin
        shadow_d   = md_en_o;
        stallCnt_d = stallCnt_q;
        if (stallNow && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // Shadow covers the cycle before muldiv reflects a new op on BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed and random bench for muldiv_issue with a behavioural muldiv unit and an issue-order scoreboard.
module tb_muldiv_issue;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } issue_t;

    logic        clk;
    logic        rst_n;
    logic        idValid;
    logic [2:0]  idCmd;
    logic [31:0] idA, idB;
    logic        flush;
    logic        mdBusy;
    logic        mdEn;
    logic [2:0]  mdOp;
    logic [31:0] mdA, mdB;
    logic        stall, rdValid, rdHi;
    logic [15:0] stallCnt;

    int compared = 0;
    int mismatched = 0;
    issue_t expQ[$];
    logic prevEn = 1'b0;

    muldiv_issue #(.W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid_i  (idValid),
        .id_cmd_i    (idCmd),
        .id_a_i      (idA),
        .id_b_i      (idB),
        .flush_i     (flush),
        .md_busy_i   (mdBusy),
        .md_en_o     (mdEn),
        .md_op_o     (mdOp),
        .md_a_o      (mdA),
        .md_b_o      (mdB),
        .stall_o     (stall),
        .rd_valid_o  (rdValid),
        .rd_hi_o     (rdHi),
        .stall_cnt_o (stallCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural muldiv: results land at the issue edge, BUSY rises one cycle late, DIV is busy 4 cycles.
    logic [31:0] mdHi, mdLo;
    logic        mdArmed;
    logic [2:0]  mdCnt;
    logic signed [63:0] prod;
    assign prod = $signed(mdA) * $signed(mdB);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdHi <= '0; mdLo <= '0; mdBusy <= 1'b0; mdArmed <= 1'b0; mdCnt <= '0;
        end else begin
            if (mdArmed) begin
                mdBusy <= 1'b1; mdArmed <= 1'b0;
            end else if (mdBusy) begin
                mdCnt <= mdCnt - 3'd1;
                if (mdCnt == 3'd1) mdBusy <= 1'b0;
            end
            if (mdEn) begin
                case (mdOp)
                    3'b000: {mdHi, mdLo} <= prod;
                    3'b001: {mdHi, mdLo} <= {mdHi, mdLo} + prod;
                    3'b010: mdLo <= mdA;
                    3'b110: mdHi <= mdA;
                    3'b011: begin
                        if (mdB != 0) begin
                            mdLo <= $signed(mdA) / $signed(mdB);
                            mdHi <= $signed(mdA) % $signed(mdB);
                        end
                        mdArmed <= 1'b1;
                        mdCnt <= 3'd4;
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [2:0] expOp(input logic [2:0] cmd);
        case (cmd)
            3'd1: return 3'b000;
            3'd2: return 3'b001;
            3'd3: return 3'b010;
            3'd4: return 3'b110;
            3'd5: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic isWriteCmd(input logic [2:0] cmd);
        return (cmd >= 3'd1) && (cmd <= 3'd5);
    endfunction

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic f);
        idValid = v; idCmd = c; idA = a; idB = b; flush = f;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            nextCycle();
        end
    endtask

    // Scoreboard: accepted write ops are queued in program order and must appear on MD_EN in that order.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            prevEn = 1'b0;
        end else begin
            if (idValid && !flush && isWriteCmd(idCmd) && !stall)
                expQ.push_back('{op: expOp(idCmd), a: idA, b: idB});
            if (mdEn) begin
                checkOutput("en_while_busy_or_shadow", {94'd0, mdBusy, prevEn}, 96'd0);
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $error("[TB] FAIL issue_order: observed unexpected issue op=%0h a=%0h b=%0h expected none",
                           mdOp, mdA, mdB);
                end else begin
                    issue_t e;
                    e = expQ.pop_front();
                    checkOutput("issue_order", {29'd0, mdOp, mdA, mdB}, {29'd0, e.op, e.a, e.b});
                end
            end
            prevEn = mdEn;
        end
    end

    int waited;
    logic held;

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 3'd1, 32'd7, 32'd9, 1'b0);

        // Reset: nothing issues, nothing stalls even with a live write on ID.
        @(negedge clk);
        checkOutput("reset_outputs", {88'd0, mdEn, stall, rdValid, rdHi, 4'd0}, 96'd0);
        checkOutput("reset_stall_cnt", {80'd0, stallCnt}, 96'd0);

        // Idle unit: MUL issues in the same cycle, MFLO waits out the shadow cycle.
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);
        checkOutput("mul_direct", {92'd0, mdEn, mdOp}, {92'd0, 1'b1, 3'b000});
        checkOutput("mul_operands", {32'd0, mdA, mdB}, {32'd0, 32'd3, 32'hFFFF_FFFE});
        checkOutput("mul_no_stall", {95'd0, stall}, 96'd0);
        nextCycle();
        applyStimulus(1'b1, 3'd6, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mflo_shadow_stall", {94'd0, stall, rdValid}, {94'd0, 2'b10});
        nextCycle();
        @(negedge clk);
        checkOutput("mflo_read", {93'd0, stall, rdValid, rdHi}, {93'd0, 3'b010});
        checkOutput("mflo_stall_cnt", {80'd0, stallCnt}, 96'd1);
        checkOutput("mul_lo", {64'd0, mdLo}, {64'd0, 32'hFFFF_FFFA});

        // DIV then MUL: MUL is buffered without stalling and issues once the unit is free.
        nextCycle();
        applyStimulus(1'b1, 3'd5, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        checkOutput("div_direct", {92'd0, mdEn, mdOp}, {92'd0, 1'b1, 3'b011});
        nextCycle();
        applyStimulus(1'b1, 3'd1, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        checkOutput("mul_buffered", {94'd0, mdEn, stall}, 96'd0);
        waited = 0;
        do begin
            nextCycle();
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            @(negedge clk);
            waited++;
        end while (!mdEn && waited < 12);
        checkOutput("buffered_issue_cycle", 96'(waited), 96'd5);
        checkOutput("buffered_issue_op", {92'd0, mdEn, mdOp}, {92'd0, 1'b1, 3'b000});
        nextCycle();
        @(negedge clk);
        checkOutput("hilo_after_mul", {32'd0, mdHi, mdLo}, {32'd0, 32'd0, 32'd25});

        // FULL and busy: a third write op stalls until the buffered op drains.
        idle(3);
        applyStimulus(1'b1, 3'd5, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        checkOutput("div2_direct", {95'd0, mdEn}, 96'd1);
        nextCycle();
        applyStimulus(1'b1, 3'd1, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        checkOutput("mul2_buffered", {94'd0, mdEn, stall}, 96'd0);
        nextCycle();
        applyStimulus(1'b1, 3'd2, 32'd1, 32'd1, 1'b0);
        waited = 0;
        forever begin
            @(negedge clk);
            if (!stall || waited >= 20) break;
            waited++;
            nextCycle();
        end
        checkOutput("full_stall_cycles", 96'(waited), 96'd4);
        checkOutput("full_drain_issue", {92'd0, mdEn, mdOp}, {92'd0, 1'b1, 3'b000});
        checkOutput("full_stall_cnt", {80'd0, stallCnt}, 96'd5);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mad_waits_shadow", {95'd0, mdEn}, 96'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("mad_issue", {92'd0, mdEn, mdOp}, {92'd0, 1'b1, 3'b001});

        // MFHI behind a DIV stalls through shadow and busy, then reads the remainder.
        idle(3);
        applyStimulus(1'b1, 3'd5, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        checkOutput("div3_direct", {95'd0, mdEn}, 96'd1);
        nextCycle();
        applyStimulus(1'b1, 3'd7, 32'd0, 32'd0, 1'b0);
        waited = 0;
        forever begin
            @(negedge clk);
            if (!stall || waited >= 20) break;
            waited++;
            nextCycle();
        end
        checkOutput("mfhi_stall_cycles", 96'(waited), 96'd5);
        checkOutput("mfhi_read", {94'd0, rdValid, rdHi}, {94'd0, 2'b11});
        checkOutput("div_hi", {64'd0, mdHi}, 96'd2);
        checkOutput("mfhi_stall_cnt", {80'd0, stallCnt}, 96'd10);

        // FULL buffer plus FLUSH: the flushed MTHI vanishes, the buffered MTLO still issues.
        idle(3);
        applyStimulus(1'b1, 3'd5, 32'd100, 32'd7, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 3'd3, 32'h55, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("mtlo_buffered", {94'd0, mdEn, stall}, 96'd0);
        nextCycle();
        applyStimulus(1'b1, 3'd4, 32'hDEAD, 32'd0, 1'b1);
        @(negedge clk);
        checkOutput("flush_quiet", {93'd0, mdEn, stall, rdValid}, 96'd0);
        waited = 0;
        do begin
            nextCycle();
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            @(negedge clk);
            waited++;
        end while (!mdEn && waited < 12);
        checkOutput("flush_buffered_issue", {60'd0, mdOp, mdA}, {60'd0, 3'b010, 32'h55});
        checkOutput("flush_issue_cycle", 96'(waited), 96'd4);
        nextCycle();
        @(negedge clk);
        checkOutput("flush_hilo", {32'd0, mdHi, mdLo}, {32'd0, 32'd2, 32'h55});

        // Reset mid-DIV with a buffered op: everything clears and the buffered op is dropped.
        idle(2);
        applyStimulus(1'b1, 3'd5, 32'd100, 32'd7, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 3'd1, 32'd9, 32'd9, 1'b0);
        nextCycle();
        rst_n = 1'b0;
        applyStimulus(1'b1, 3'd1, 32'd4, 32'd4, 1'b0);
        @(negedge clk);
        checkOutput("midreset_outputs", {20'd0, mdEn, stall, rdValid, rdHi, mdOp, mdA, mdB, 1'b0},
                    96'd0);
        checkOutput("midreset_stall_cnt", {80'd0, stallCnt}, 96'd0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_empty", {94'd0, mdEn, stall}, 96'd0);
        nextCycle();
        applyStimulus(1'b1, 3'd4, 32'h1234, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_direct", {92'd0, mdEn, mdOp}, {92'd0, 1'b1, 3'b110});

        // Random command stream; a stalled op is held on ID like a real decode stage.
        idle(4);
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                applyStimulus(($urandom % 4) != 0, 3'($urandom % 8), $urandom,
                              32'($urandom_range(1, 1000)), ($urandom % 10) == 0);
            end
            @(negedge clk);
            held = stall;
            nextCycle();
        end
        idle(12);
        checkOutput("drain_queue_empty", 96'(expQ.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
